// File: rtl/sha1_text_overlay_if.sv
// -----------------------------------------------------------------------------
// sha1_text_overlay_if
//   Digest handshake between a SHA1 producer and the text overlay.
//   i_digest        : 160-bit digest, bits 159:156 are the first hex character
//   i_digest_valid  : producer is offering i_digest
//   o_digest_ready  : overlay can take a digest this cycle
//   master modport  : digest producer
//   slave modport   : sha1_text_overlay
// -----------------------------------------------------------------------------
interface sha1_text_overlay_if;
    logic [159:0] i_digest;
    logic         i_digest_valid;
    logic         o_digest_ready;

    modport master (
        output i_digest,
        output i_digest_valid,
        input  o_digest_ready
    );

    modport slave (
        input  i_digest,
        input  i_digest_valid,
        output o_digest_ready
    );
endinterface

// File: rtl/sha1_text_overlay.sv
// -----------------------------------------------------------------------------
// sha1_text_overlay
//   Renders a 160-bit SHA1 digest as 40 hex characters (8x16 glyphs) in a
//   320x16 box on a 640x480-style pixel stream. A new digest is parked in a
//   shadow register and only copied to the display register at frame start,
//   so the text on screen never changes mid-frame.
//
//   Ports:
//     clk            : pixel clock, one pixel per cycle
//     rst            : synchronous, active-low reset
//     dig            : digest handshake (slave side of sha1_text_overlay_if)
//     i_pix_x/y      : pixel counters (x 0..799, y 0..524)
//     i_pix_active   : pixel is in the addressable region
//     o_red/green/blue : 4-bit colour, identical on all channels
//     o_pix_active   : i_pix_active delayed by 2 clk to match the colour
// -----------------------------------------------------------------------------
module sha1_text_overlay #(
    parameter int         TEXT_X0 = 208,
    parameter int         TEXT_Y0 = 259,
    parameter logic [3:0] FG      = 4'hF,
    parameter logic [3:0] BG      = 4'h2
) (
    input  logic                clk,
    input  logic                rst,
    sha1_text_overlay_if.slave  dig,
    input  logic [9:0]          i_pix_x,
    input  logic [9:0]          i_pix_y,
    input  logic                i_pix_active,
    output logic [3:0]          o_red,
    output logic [3:0]          o_green,
    output logic [3:0]          o_blue,
    output logic                o_pix_active
);

    // Box bounds in 11 bits so TEXT_X0+319 cannot wrap a 10-bit compare.
    localparam logic [10:0] X_LO = 11'(TEXT_X0);
    localparam logic [10:0] X_HI = 11'(TEXT_X0 + 319);
    localparam logic [10:0] Y_LO = 11'(TEXT_Y0);
    localparam logic [10:0] Y_HI = 11'(TEXT_Y0 + 15);

    typedef enum logic [1:0] {
        EMPTY,
        WAIT_FRAME,
        SHOW
    } state_t;

    // -------------------------------------------------------------------------
    // Font ROM: glyphs 0-9, A-F. Only rows 2..12 carry pixels; rows 0, 1, 13,
    // 14, 15 and column 7 (bit 0) are blank to space characters and lines.
    // Each constant holds rows 2..12, row 2 in the top byte.
    // -------------------------------------------------------------------------
    function automatic logic [7:0] font_row(input logic [3:0] glyph,
                                            input logic [3:0] row);
        logic [87:0] g;
        logic [6:0]  lsb;
        g = '0;
        case (glyph)
            4'h0: g = 88'h3C_42_42_46_4A_52_62_42_42_42_3C;
            4'h1: g = 88'h08_18_28_08_08_08_08_08_08_08_3E;
            4'h2: g = 88'h3C_42_02_02_04_08_10_20_40_40_7E;
            4'h3: g = 88'h3C_42_02_02_1C_02_02_02_02_42_3C;
            4'h4: g = 88'h04_0C_14_24_44_44_7E_04_04_04_04;
            4'h5: g = 88'h7E_40_40_40_7C_02_02_02_02_42_3C;
            4'h6: g = 88'h3C_42_40_40_7C_42_42_42_42_42_3C;
            4'h7: g = 88'h7E_02_02_04_04_08_08_10_10_20_20;
            4'h8: g = 88'h3C_42_42_42_3C_42_42_42_42_42_3C;
            4'h9: g = 88'h3C_42_42_42_42_3E_02_02_02_42_3C;
            4'hA: g = 88'h18_24_42_42_42_7E_42_42_42_42_42;
            4'hB: g = 88'h7C_42_42_42_7C_42_42_42_42_42_7C;
            4'hC: g = 88'h3C_42_40_40_40_40_40_40_40_42_3C;
            4'hD: g = 88'h78_44_42_42_42_42_42_42_42_44_78;
            4'hE: g = 88'h7E_40_40_40_40_7C_40_40_40_40_7E;
            4'hF: g = 88'h7E_40_40_40_40_7C_40_40_40_40_40;
            default: g = '0;
        endcase
        font_row = 8'h00;
        lsb      = '0;
        if (row >= 4'd2 && row <= 4'd12) begin
            // Row r lives at bits [96-8r +: 8].
            lsb      = 7'd96 - {row, 3'b000};
            font_row = g[lsb +: 8];
        end
    endfunction

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    state_t       state, state_next;
    logic         ready_q;
    logic         shown;
    logic [159:0] shadow;
    logic [159:0] display;
    logic         capture;
    logic         transfer;
    logic         accept;
    logic         frame_start;

    assign accept      = dig.i_digest_valid && ready_q;
    assign frame_start = (i_pix_x == 10'd0) && (i_pix_y == 10'd0);

    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips the assignment would infer a latch.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        transfer   = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    capture    = 1'b1;
                    state_next = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (frame_start) begin
                    transfer   = 1'b1;
                    state_next = SHOW;
                end
            end
            SHOW: begin
                // A frame start coinciding with an accept does not transfer;
                // the new digest waits for the next frame start.
                if (accept) begin
                    capture    = 1'b1;
                    state_next = WAIT_FRAME;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
            shown   <= 1'b0;
            shadow  <= '0;
            display <= '0;
        end else begin
            state   <= state_next;
            // Registered so ready is held low during reset and rises on the
            // first edge after release.
            ready_q <= (state_next != WAIT_FRAME);
            if (capture) begin
                shadow <= dig.i_digest;
            end
            if (transfer) begin
                display <= shadow;
                shown   <= 1'b1;
            end
        end
    end

    assign dig.o_digest_ready = ready_q;

    // -------------------------------------------------------------------------
    // Stage 1: box hit and glyph addressing
    // -------------------------------------------------------------------------
    logic [10:0] x11, y11, dx, dy;
    logic        hit;

    assign x11 = {1'b0, i_pix_x};
    assign y11 = {1'b0, i_pix_y};
    assign dx  = x11 - X_LO;
    assign dy  = y11 - Y_LO;
    assign hit = (x11 >= X_LO) && (x11 <= X_HI) && (y11 >= Y_LO) && (y11 <= Y_HI);

    logic       s1_active;
    logic       s1_hit;
    logic [5:0] s1_char;
    logic [3:0] s1_row;
    logic [2:0] s1_col;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_active <= 1'b0;
            s1_hit    <= 1'b0;
            s1_char   <= '0;
            s1_row    <= '0;
            s1_col    <= '0;
        end else begin
            s1_active <= i_pix_active;
            s1_hit    <= hit;
            s1_char   <= dx[8:3];
            s1_row    <= dy[3:0];
            s1_col    <= dx[2:0];
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: nibble select, font lookup, colour
    // -------------------------------------------------------------------------
    logic [7:0]   nib_lo;
    logic [159:0] nib_shift;
    logic [3:0]   nibble;
    logic [7:0]   row_bits;
    logic         glyph_bit;
    logic [3:0]   colour;

    // Character c occupies display[159-4c -: 4], i.e. its LSB is at 156-4c.
    assign nib_lo    = 8'd156 - {s1_char, 2'b00};
    assign nib_shift = display >> nib_lo;
    assign nibble    = nib_shift[3:0];
    assign row_bits  = font_row(nibble, s1_row);
    assign glyph_bit = row_bits[3'd7 - s1_col];

    always_comb begin
        colour = 4'h0;
        if (s1_active && s1_hit) begin
            colour = (shown && glyph_bit) ? FG : BG;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            o_red        <= 4'h0;
            o_green      <= 4'h0;
            o_blue       <= 4'h0;
            o_pix_active <= 1'b0;
        end else begin
            o_red        <= colour;
            o_green      <= colour;
            o_blue       <= colour;
            o_pix_active <= s1_active;
        end
    end

endmodule
